twiddle_mul: RTL
================

Name: twiddle_mul

Overview:
- Downstream neighbour of the radix-2 butterfly stage in the 512-point FFT datapath.
- Takes the butterfly's NUM-lane sum (din1) and difference (din2) streams.
- Multiplies each difference sample by its twiddle factor W_512^n; the sum path is delay-matched alongside.
- Rounds and saturates, then presents both paths to the next FFT stage with a frame marker.

Parameters:
- IN_WIDTH, 10, signed input sample width (butterfly output width).
- OUT_WIDTH, 10, signed output width; must be >= IN_WIDTH.
- TW_WIDTH, 9, signed twiddle width, fixed-point s1.7 (128 = +1.0).
- NUM, 16, parallel lanes.
- DATA, 512, FFT points.
- BEATS, DATA/(2*NUM) = 16, valid beats per frame.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- din1_re  in  [IN_WIDTH-1:0] x [0:NUM-1]  butterfly sum, real
- din1_im  in  [IN_WIDTH-1:0] x [0:NUM-1]  butterfly sum, imag
- din2_re  in  [IN_WIDTH-1:0] x [0:NUM-1]  butterfly difference, real
- din2_im  in  [IN_WIDTH-1:0] x [0:NUM-1]  butterfly difference, imag
- valid_in  in  1  input beat valid
- dout1_re, dout1_im  out  [OUT_WIDTH-1:0] x [0:NUM-1]  delayed sum path
- dout2_re, dout2_im  out  [OUT_WIDTH-1:0] x [0:NUM-1]  twiddled difference path
- valid_out  out  1  output beat valid
- frame_last  out  1  high with the output beat carrying beat index BEATS-1

Behaviour:
- Clock and reset: single clock clk; reset rstn is synchronous and active-low.
- Reset values: all outputs, pipeline registers and the beat counter are 0.
- Reset mid-frame discards in-flight beats; the next valid_in is beat 0.
- Beat counter (0..BEATS-1):
  - increments on each valid_in cycle;
  - wraps BEATS-1 -> 0;
  - holds during valid_in gaps.
- Twiddle index: n = beat*NUM + lane, range 0..255.
- Twiddle values: constant table, c = round(128*cos(2*pi*n/512)), d = round(-128*sin(2*pi*n/512)).
  - W^0 = (128, 0); W^128 = (0, -128).
- Pipeline: 3 stages, no backpressure, latency exactly 3 cycles valid_in -> valid_out.
  - S1: register inputs, twiddle (c, d) and beat index; valid bit.
  - S2: register four products a*c, b*d, a*d, b*c, each IN_WIDTH+TW_WIDTH bits signed.
  - S3: compute re = ac - bd and im = ad + bc at IN_WIDTH+TW_WIDTH+1 bits.
    - Add 64, arithmetic shift right 7 (round half up).
    - Saturate to OUT_WIDTH and register.
- Sum path: din1 is sign-extended to OUT_WIDTH and delayed 3 stages, aligned with dout2.
- Clock enables: data registers in each stage load only when that stage's valid is 1. With valid low, outputs hold their last value and valid_out = 0.
- valid_out equals valid_in delayed 3 cycles, so gaps are preserved.
- frame_last is the S3-registered flag (beat == BEATS-1).
- Back-to-back frames: beat BEATS-1 followed immediately by beat 0 is legal; frame_last pulses for exactly one cycle.

Optional Feature:
- Macro TWMUL_SAT_EN.
- Defined: the S3 result clamps to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- Undefined: the S3 result is truncated to OUT_WIDTH LSBs (two's-complement wrap); no clamp logic is built.

Test Plan:
- Reset: hold rstn=0 while valid_in=1 with nonzero data -> all outputs 0, valid_out 0. First valid after release is beat 0.
- Beat 0, lane 0, din2=(100,-50) -> dout2 lane 0 = (100,-50) three cycles later, with valid_out=1. din1=(-7,3) -> dout1=(-7,3).
- Beat 8, lane 0 (n=128), din2=(100,-50) -> dout2=(-50,-100), which checks floor rounding of -49.5 and -99.5.
- Beat 2, lane 0 (n=32, W=(118,-49)), din2=(511,511):
  - TWMUL_SAT_EN defined -> dout2=(511,275);
  - TWMUL_SAT_EN undefined -> (-357,275).
- 16 valid beats, a 3-cycle gap, then 16 more beats -> valid_out reproduces the gap. frame_last is high only on output beats 15 and 31, and the beat index resumes correctly after the gap.
- Assert rstn=0 for 1 cycle at beat 5 -> valid_out is 0 for the following 3 cycles. The next input is treated as beat 0 (W^lane twiddles).

Source files
------------

// File: rtl/twiddle_mul.sv
// twiddle_mul: complex twiddle multiply stage following the radix-2 butterfly
// of the 512-point FFT. The difference stream (din2) of each of the NUM lanes
// is multiplied by W_DATA^n with n = beat*NUM + lane, rounded (half up) and
// fitted to OUT_WIDTH. The sum stream (din1) is sign-extended and delayed so
// both paths leave together, 3 cycles after valid_in.
//
// Ports:
//   clk, rstn          clock, synchronous active-low reset
//   din1_re/im [NUM]   butterfly sum (IN_WIDTH signed)
//   din2_re/im [NUM]   butterfly difference (IN_WIDTH signed)
//   valid_in           input beat valid
//   dout1_re/im [NUM]  delayed sum path (OUT_WIDTH signed)
//   dout2_re/im [NUM]  twiddled difference path (OUT_WIDTH signed)
//   valid_out          output beat valid
//   frame_last         output beat is beat BEATS-1 of the frame
//
// Build option: define TWMUL_SAT_EN to clamp the twiddled result to the
// OUT_WIDTH range; otherwise the result wraps (LSBs kept).
module twiddle_mul #(
  parameter int unsigned IN_WIDTH  = 10,
  parameter int unsigned OUT_WIDTH = 10,
  parameter int unsigned TW_WIDTH  = 9,
  parameter int unsigned NUM       = 16,
  parameter int unsigned DATA      = 512
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [IN_WIDTH-1:0]  din1_re [0:NUM-1],
  input  logic [IN_WIDTH-1:0]  din1_im [0:NUM-1],
  input  logic [IN_WIDTH-1:0]  din2_re [0:NUM-1],
  input  logic [IN_WIDTH-1:0]  din2_im [0:NUM-1],
  input  logic                 valid_in,
  output logic [OUT_WIDTH-1:0] dout1_re [0:NUM-1],
  output logic [OUT_WIDTH-1:0] dout1_im [0:NUM-1],
  output logic [OUT_WIDTH-1:0] dout2_re [0:NUM-1],
  output logic [OUT_WIDTH-1:0] dout2_im [0:NUM-1],
  output logic                 valid_out,
  output logic                 frame_last
);

  localparam int unsigned BEATS    = DATA / (2 * NUM);
  localparam int unsigned BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned PROD_W   = IN_WIDTH + TW_WIDTH;
  localparam int unsigned FULL_W   = PROD_W + 1;
  localparam int unsigned FRAC     = TW_WIDTH - 2;
  localparam int unsigned NTW      = DATA / 2;
  localparam int unsigned QTW      = DATA / 4;
  localparam int unsigned TAB_BITS = NTW * TW_WIDTH;
  localparam int unsigned TAB_IW   = $clog2(TAB_BITS);

  localparam logic signed [FULL_W-1:0] RND = FULL_W'(64'sd1 <<< (FRAC - 1));

`ifdef TWMUL_SAT_EN
  localparam longint SAT_MAX = (64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1;
  localparam longint SAT_MIN = -SAT_MAX - 64'sd1;
`endif

  // round(2^FRAC * cos(2*pi*k/DATA)) for k in 0..DATA/4, integer Taylor series
  // in 2^30 fixed point so the table is built without real arithmetic.
  function automatic int quarter_cos(input int k);
    longint th;
    longint th2;
    longint term;
    longint acc;
    th   = (64'sd3373259426 * 64'sd2 * longint'(k)) / longint'(DATA);
    th2  = (th * th) >>> 30;
    term = 64'sd1 <<< 30;
    acc  = term;
    for (int i = 1; i <= 12; i++) begin
      term = -((term * th2) >>> 30) / longint'((2 * i - 1) * (2 * i));
      acc  = acc + term;
    end
    return int'(((acc <<< FRAC) + (64'sd1 <<< 29)) >>> 30);
  endfunction

  // Real part c of W^n over the half circle, folded onto the quarter wave.
  function automatic logic [TW_WIDTH-1:0] tw_c(input int n);
    if (n <= int'(QTW)) return TW_WIDTH'(quarter_cos(n));
    return TW_WIDTH'(-quarter_cos(int'(NTW) - n));
  endfunction

  // Imaginary part d = -sin of W^n.
  function automatic logic [TW_WIDTH-1:0] tw_d(input int n);
    if (n <= int'(QTW)) return TW_WIDTH'(-quarter_cos(int'(QTW) - n));
    return TW_WIDTH'(-quarter_cos(n - int'(QTW)));
  endfunction

  function automatic logic [TAB_BITS-1:0] build_tab(input logic sel_d);
    logic [TAB_BITS-1:0] t;
    t = '0;
    for (int n = 0; n < int'(NTW); n++) begin
      t[n*TW_WIDTH +: TW_WIDTH] = sel_d ? tw_d(n) : tw_c(n);
    end
    return t;
  endfunction

  localparam logic [TAB_BITS-1:0] TAB_C = build_tab(1'b0);
  localparam logic [TAB_BITS-1:0] TAB_D = build_tab(1'b1);

  // Clamp (optional) or wrap a full-precision result to OUT_WIDTH.
  function automatic logic [OUT_WIDTH-1:0] fit(input logic signed [FULL_W-1:0] x);
`ifdef TWMUL_SAT_EN
    if (longint'(x) > SAT_MAX) return OUT_WIDTH'(SAT_MAX);
    if (longint'(x) < SAT_MIN) return OUT_WIDTH'(SAT_MIN);
`endif
    return OUT_WIDTH'(x);
  endfunction

  logic [BEAT_W-1:0] r_beat;

  logic                        r1_valid;
  logic                        r1_last;
  logic signed [IN_WIDTH-1:0]  r1_x_re [NUM];
  logic signed [IN_WIDTH-1:0]  r1_x_im [NUM];
  logic signed [IN_WIDTH-1:0]  r1_s_re [NUM];
  logic signed [IN_WIDTH-1:0]  r1_s_im [NUM];
  logic signed [TW_WIDTH-1:0]  r1_tw_c [NUM];
  logic signed [TW_WIDTH-1:0]  r1_tw_d [NUM];

  logic                        r2_valid;
  logic                        r2_last;
  logic signed [PROD_W-1:0]    r2_ac [NUM];
  logic signed [PROD_W-1:0]    r2_bd [NUM];
  logic signed [PROD_W-1:0]    r2_ad [NUM];
  logic signed [PROD_W-1:0]    r2_bc [NUM];
  logic signed [IN_WIDTH-1:0]  r2_s_re [NUM];
  logic signed [IN_WIDTH-1:0]  r2_s_im [NUM];

  logic [TAB_IW-1:0]           w_pos [NUM];
  logic signed [FULL_W-1:0]    w_re [NUM];
  logic signed [FULL_W-1:0]    w_im [NUM];

  // Bit position of twiddle n = beat*NUM + lane inside the packed tables.
  always_comb begin
    for (int l = 0; l < int'(NUM); l++) begin
      w_pos[l] = TAB_IW'((int'(r_beat) * int'(NUM) + l) * int'(TW_WIDTH));
    end
  end

  // S1: beat counter, input capture and twiddle lookup.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_beat   <= '0;
      r1_valid <= 1'b0;
      r1_last  <= 1'b0;
      for (int l = 0; l < int'(NUM); l++) begin
        r1_x_re[l] <= '0;
        r1_x_im[l] <= '0;
        r1_s_re[l] <= '0;
        r1_s_im[l] <= '0;
        r1_tw_c[l] <= '0;
        r1_tw_d[l] <= '0;
      end
    end else begin
      r1_valid <= valid_in;
      if (valid_in) begin
        r_beat  <= (r_beat == BEAT_W'(BEATS - 1)) ? '0 : r_beat + BEAT_W'(1);
        r1_last <= (r_beat == BEAT_W'(BEATS - 1));
        for (int l = 0; l < int'(NUM); l++) begin
          r1_x_re[l] <= din2_re[l];
          r1_x_im[l] <= din2_im[l];
          r1_s_re[l] <= din1_re[l];
          r1_s_im[l] <= din1_im[l];
          r1_tw_c[l] <= TAB_C[w_pos[l] +: TW_WIDTH];
          r1_tw_d[l] <= TAB_D[w_pos[l] +: TW_WIDTH];
        end
      end
    end
  end

  // S2: the four partial products.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r2_valid <= 1'b0;
      r2_last  <= 1'b0;
      for (int l = 0; l < int'(NUM); l++) begin
        r2_ac[l]   <= '0;
        r2_bd[l]   <= '0;
        r2_ad[l]   <= '0;
        r2_bc[l]   <= '0;
        r2_s_re[l] <= '0;
        r2_s_im[l] <= '0;
      end
    end else begin
      r2_valid <= r1_valid;
      if (r1_valid) begin
        r2_last <= r1_last;
        for (int l = 0; l < int'(NUM); l++) begin
          r2_ac[l]   <= PROD_W'(r1_x_re[l]) * PROD_W'(r1_tw_c[l]);
          r2_bd[l]   <= PROD_W'(r1_x_im[l]) * PROD_W'(r1_tw_d[l]);
          r2_ad[l]   <= PROD_W'(r1_x_re[l]) * PROD_W'(r1_tw_d[l]);
          r2_bc[l]   <= PROD_W'(r1_x_im[l]) * PROD_W'(r1_tw_c[l]);
          r2_s_re[l] <= r1_s_re[l];
          r2_s_im[l] <= r1_s_im[l];
        end
      end
    end
  end

  // Combine, add half an LSB and drop the FRAC fraction bits (floor).
  always_comb begin
    for (int l = 0; l < int'(NUM); l++) begin
      w_re[l] = (FULL_W'(r2_ac[l]) - FULL_W'(r2_bd[l]) + RND) >>> FRAC;
      w_im[l] = (FULL_W'(r2_ad[l]) + FULL_W'(r2_bc[l]) + RND) >>> FRAC;
    end
  end

  // S3: output registers; frame_last only accompanies a valid beat.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_out  <= 1'b0;
      frame_last <= 1'b0;
      for (int l = 0; l < int'(NUM); l++) begin
        dout1_re[l] <= '0;
        dout1_im[l] <= '0;
        dout2_re[l] <= '0;
        dout2_im[l] <= '0;
      end
    end else begin
      valid_out  <= r2_valid;
      frame_last <= r2_valid & r2_last;
      if (r2_valid) begin
        for (int l = 0; l < int'(NUM); l++) begin
          dout1_re[l] <= OUT_WIDTH'(r2_s_re[l]);
          dout1_im[l] <= OUT_WIDTH'(r2_s_im[l]);
          dout2_re[l] <= fit(w_re[l]);
          dout2_im[l] <= fit(w_im[l]);
        end
      end
    end
  end

endmodule
